// File: rtl/ones_generator_if.sv
// Handshake and data bundle between a ones_generator and the logic driving it.
// The master requests a run; the slave (the generator) returns status and the vector.
interface ones_generator_if #(
    parameter int INPUT_FEATURES = 8
);
    localparam int CW = $clog2(INPUT_FEATURES + 1);

    logic                      start_i;
    logic [CW-1:0]             ones_i;
    logic                      busy_o;
    logic                      done_o;
    logic                      sat_o;
    logic [INPUT_FEATURES-1:0] features_o;

    modport master (
        output start_i,
        output ones_i,
        input  busy_o,
        input  done_o,
        input  sat_o,
        input  features_o
    );

    modport slave (
        input  start_i,
        input  ones_i,
        output busy_o,
        output done_o,
        output sat_o,
        output features_o
    );
endinterface

// File: rtl/ones_generator.sv
// Serial count-to-thermometer decoder: builds a vector with the requested number
// of LSB-first HIGH bits, one bit per falling clock edge.
module ones_generator #(
    parameter int INPUT_FEATURES = 8
) (
    input logic              clock_i,
    input logic              reset_i,
    ones_generator_if.slave  bus
);
    localparam int CW = $clog2(INPUT_FEATURES + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(INPUT_FEATURES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic [CW-1:0]             idx_r, idx_s;
    logic [CW-1:0]             remaining_r, remaining_s;
    logic [INPUT_FEATURES-1:0] features_r, features_s;
    logic                      sat_r, sat_s;
    logic                      busy_r, busy_s;
    logic                      done_r, done_s;

    // Next-state and next-output computation for the fill sequencer.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        remaining_s = remaining_r;
        features_s  = features_r;
        sat_s       = sat_r;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    // Clip at acceptance so idx can never run past the vector.
                    remaining_s = (bus.ones_i > MAX_COUNT) ? MAX_COUNT : bus.ones_i;
                    sat_s       = (bus.ones_i > MAX_COUNT);
                    features_s  = {INPUT_FEATURES{1'b0}};
                    idx_s       = {CW{1'b0}};
                    state_s     = FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (remaining_r != {CW{1'b0}}) begin
                    for (int i = 0; i < INPUT_FEATURES; i++) begin
                        if (idx_r == CW'(i)) begin
                            features_s[i] = 1'b1;
                        end else begin
                            features_s[i] = features_r[i];
                        end
                    end
                    idx_s       = idx_r + CW'(1);
                    remaining_s = remaining_r - CW'(1);
                end else begin
                    idx_s       = idx_r;
                    remaining_s = remaining_r;
                end
                if (remaining_r <= CW'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = FILL;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State and output registers, updated on the falling edge to match ones_counter.
    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            idx_r       <= {CW{1'b0}};
            remaining_r <= {CW{1'b0}};
            features_r  <= {INPUT_FEATURES{1'b0}};
            sat_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            remaining_r <= remaining_s;
            features_r  <= features_s;
            sat_r       <= sat_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign bus.busy_o     = busy_r;
    assign bus.done_o     = done_r;
    assign bus.sat_o      = sat_r;
    assign bus.features_o = features_r;
endmodule

// File: tb/tb_ones_generator.sv
// Directed bench for ones_generator: an 8-bit instance for the scenario tests
// and a 13-bit instance for the count sweep.
module tb_ones_generator;
    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    ones_generator_if #(.INPUT_FEATURES(8))  bus8();
    ones_generator_if #(.INPUT_FEATURES(13)) bus13();

    ones_generator #(.INPUT_FEATURES(8)) dut8 (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus8)
    );

    ones_generator #(.INPUT_FEATURES(13)) dut13 (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus13)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change and outputs are sampled on the rising edge, away from the active falling edge.
    task automatic step();
        @(posedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total_cnt++; if (bus8.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus8.busy_o); else pass_cnt++;
        total_cnt++; if (bus8.done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", bus8.done_o); else pass_cnt++;
        total_cnt++; if (bus8.sat_o !== 1'b0) $display("FAIL reset_sat: got %b want 0", bus8.sat_o); else pass_cnt++;
        total_cnt++; if (bus8.features_o !== 8'h00) $display("FAIL reset_features: got %h want 00", bus8.features_o); else pass_cnt++;
        // Reset wins over a simultaneous start.
        bus8.start_i = 1'b1;
        bus8.ones_i  = 4'd3;
        step();
        bus8.start_i = 1'b0;
        total_cnt++; if (bus8.busy_o !== 1'b0) $display("FAIL reset_priority_busy: got %b want 0", bus8.busy_o); else pass_cnt++;
        reset = 1'b0;
        step();
    endtask

    // One full run on the 8-bit instance; cycles is the expected number of FILL edges.
    task automatic run8(input string name, input logic [3:0] n, input logic [7:0] exp_feat,
                        input logic exp_sat, input int cycles);
        int c;
        bus8.start_i = 1'b1;
        bus8.ones_i  = n;
        step();
        bus8.start_i = 1'b0;
        bus8.ones_i  = 4'd0;
        total_cnt++; if (bus8.busy_o !== 1'b1 || bus8.done_o !== 1'b0)
            $display("FAIL %s_accept: got busy=%b done=%b want busy=1 done=0", name, bus8.busy_o, bus8.done_o); else pass_cnt++;
        c = 0;
        while (bus8.done_o !== 1'b1 && c < 20) begin
            step();
            c++;
        end
        total_cnt++; if (c !== cycles) $display("FAIL %s_latency: got %0d want %0d", name, c, cycles); else pass_cnt++;
        total_cnt++; if (bus8.features_o !== exp_feat) $display("FAIL %s_features: got %h want %h", name, bus8.features_o, exp_feat); else pass_cnt++;
        total_cnt++; if (bus8.sat_o !== exp_sat) $display("FAIL %s_sat: got %b want %b", name, bus8.sat_o, exp_sat); else pass_cnt++;
        step();
        total_cnt++; if (bus8.done_o !== 1'b0 || bus8.busy_o !== 1'b0)
            $display("FAIL %s_end: got busy=%b done=%b want 0 0", name, bus8.busy_o, bus8.done_o); else pass_cnt++;
    endtask

    task automatic test_nominal();
        logic [7:0] exp_seq [0:3];
        exp_seq[0] = 8'h00; exp_seq[1] = 8'h01; exp_seq[2] = 8'h03; exp_seq[3] = 8'h07;
        bus8.start_i = 1'b1;
        bus8.ones_i  = 4'd3;
        step();
        bus8.start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (bus8.features_o !== exp_seq[i])
                $display("FAIL nominal_bit_%0d: got %h want %h", i, bus8.features_o, exp_seq[i]); else pass_cnt++;
            total_cnt++; if (bus8.done_o !== (i == 3))
                $display("FAIL nominal_done_%0d: got %b want %b", i, bus8.done_o, (i == 3)); else pass_cnt++;
            if (i < 3) step();
        end
        step();
        total_cnt++; if (bus8.done_o !== 1'b0 || bus8.busy_o !== 1'b0 || bus8.features_o !== 8'h07 || bus8.sat_o !== 1'b0)
            $display("FAIL nominal_hold: got done=%b busy=%b feat=%h sat=%b want 0 0 07 0",
                     bus8.done_o, bus8.busy_o, bus8.features_o, bus8.sat_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus8.start_i = 1'b1;
        bus8.ones_i  = 4'd5;
        step();
        bus8.start_i = 1'b0;
        step(); step(); step();
        total_cnt++; if (bus8.features_o !== 8'h07) $display("FAIL midreset_pre: got %h want 07", bus8.features_o); else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++; if (bus8.features_o !== 8'h00 || bus8.busy_o !== 1'b0 || bus8.done_o !== 1'b0)
            $display("FAIL midreset_clear: got feat=%h busy=%b done=%b want 00 0 0",
                     bus8.features_o, bus8.busy_o, bus8.done_o); else pass_cnt++;
        run8("after_reset", 4'd2, 8'h03, 1'b0, 2);
    endtask

    task automatic test_ignored_start();
        int dones;
        bus8.start_i = 1'b1;
        bus8.ones_i  = 4'd4;
        step();
        bus8.start_i = 1'b0;
        dones = 0;
        step();
        bus8.start_i = 1'b1;
        bus8.ones_i  = 4'd7;
        step();
        bus8.start_i = 1'b0;
        for (int i = 0; i < 10 && bus8.done_o !== 1'b1; i++) step();
        dones += int'(bus8.done_o);
        bus8.start_i = 1'b1;
        step();
        bus8.start_i = 1'b0;
        dones += int'(bus8.done_o);
        step();
        dones += int'(bus8.done_o);
        total_cnt++; if (bus8.features_o !== 8'h0F) $display("FAIL ignored_features: got %h want 0F", bus8.features_o); else pass_cnt++;
        total_cnt++; if (bus8.busy_o !== 1'b0) $display("FAIL ignored_not_queued: got busy=%b want 0", bus8.busy_o); else pass_cnt++;
        total_cnt++; if (dones !== 1) $display("FAIL ignored_done_pulses: got %0d want 1", dones); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus8.start_i = 1'b1;
        bus8.ones_i  = 4'd2;
        step();
        step(); step();
        total_cnt++; if (bus8.done_o !== 1'b1) $display("FAIL b2b_done: got %b want 1", bus8.done_o); else pass_cnt++;
        step();
        total_cnt++; if (bus8.busy_o !== 1'b0) $display("FAIL b2b_idle: got %b want 0", bus8.busy_o); else pass_cnt++;
        step();
        bus8.start_i = 1'b0;
        total_cnt++; if (bus8.busy_o !== 1'b1 || bus8.features_o !== 8'h00)
            $display("FAIL b2b_restart: got busy=%b feat=%h want 1 00", bus8.busy_o, bus8.features_o); else pass_cnt++;
        for (int i = 0; i < 10 && bus8.done_o !== 1'b1; i++) step();
        total_cnt++; if (bus8.features_o !== 8'h03) $display("FAIL b2b_features: got %h want 03", bus8.features_o); else pass_cnt++;
        step();
    endtask

    task automatic test_round_trip();
        int c;
        int m;
        logic [12:0] exp_feat;
        for (int n = 0; n < 16; n++) begin
            m = (n > 13) ? 13 : n;
            exp_feat = 13'h0000;
            for (int b = 0; b < m; b++) exp_feat[b] = 1'b1;
            bus13.start_i = 1'b1;
            bus13.ones_i  = 4'(n);
            step();
            bus13.start_i = 1'b0;
            c = 0;
            while (bus13.done_o !== 1'b1 && c < 30) begin
                step();
                c++;
            end
            total_cnt++; if (c !== ((m == 0) ? 1 : m)) $display("FAIL rt_latency_%0d: got %0d want %0d", n, c, (m == 0) ? 1 : m); else pass_cnt++;
            total_cnt++; if (bus13.features_o !== exp_feat) $display("FAIL rt_features_%0d: got %h want %h", n, bus13.features_o, exp_feat); else pass_cnt++;
            total_cnt++; if ($countones(bus13.features_o) !== m) $display("FAIL rt_count_%0d: got %0d want %0d", n, $countones(bus13.features_o), m); else pass_cnt++;
            total_cnt++; if (bus13.sat_o !== (n > 13)) $display("FAIL rt_sat_%0d: got %b want %b", n, bus13.sat_o, (n > 13)); else pass_cnt++;
            step();
        end
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b1;
        bus8.start_i  = 1'b0;
        bus8.ones_i   = 4'd0;
        bus13.start_i = 1'b0;
        bus13.ones_i  = 4'd0;
        step();
        test_reset();
        test_nominal();
        test_reset_mid();
        run8("zero", 4'd0, 8'h00, 1'b0, 1);
        run8("full", 4'd8, 8'hFF, 1'b0, 8);
        run8("sat", 4'd15, 8'hFF, 1'b1, 8);
        run8("after_sat", 4'd1, 8'h01, 1'b0, 1);
        test_ignored_start();
        test_back_to_back();
        test_round_trip();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ones_generator.md
# ones_generator

Serial count-to-vector decoder, the inverse of `ones_counter`: accepts a ones count and builds an `INPUT_FEATURES`-wide feature vector containing exactly that many HIGH bits, LSB-first (thermometer code), one bit per clock. Used to regenerate feature vectors from stored counts and to drive self-checking loops where `features_o` feeds a `ones_counter` instance. All state is updated on the falling edge of `clock_i`, matching `ones_counter`, so the two share timing when chained.

## Interface

Parameters:
- `INPUT_FEATURES`, default 8: width of the generated feature vector; must be ≥ 1.

Ports (CW = `$clog2(INPUT_FEATURES + 1)`):
- `clock_i`  input  1  clock; all state updates on the falling edge.
- `reset_i`  input  1  reset, synchronous, active-high.
- `start_i`  input  1  request to generate a vector; accepted only in IDLE.
- `ones_i`  input  CW  requested ones count; sampled on the accepting edge.
- `busy_o`  output  1  high in FILL and DONE.
- `done_o`  output  1  one-cycle pulse: vector complete.
- `sat_o`  output  1  request exceeded `INPUT_FEATURES` and was clipped; valid from acceptance until the next accepted start.
- `features_o`  output  INPUT_FEATURES  generated vector; bit i HIGH iff i < applied count.

## Operation

- Internal state: FSM {IDLE, FILL, DONE}; bit index `idx` (CW bits); `remaining` (CW bits).
- IDLE: `busy_o`=0. On an edge with `start_i`=1: `remaining` ← min(`ones_i`, `INPUT_FEATURES`); `sat_o` ← (`ones_i` > `INPUT_FEATURES`); `features_o` ← 0; `idx` ← 0; go to FILL.
- FILL, each edge:
  - if `remaining` ≠ 0: `features_o[idx]` ← 1, `idx` ← `idx`+1, `remaining` ← `remaining`−1.
  - if `remaining` ≤ 1 before the edge: go to DONE.
- DONE: `done_o`=1 for exactly this cycle; next edge returns to IDLE.
- `features_o` and `sat_o` hold their values in IDLE until the next accepted start.
- Arithmetic: `idx` never exceeds `INPUT_FEATURES`; no write to `features_o[idx]` when `idx` ≥ `INPUT_FEATURES`. No wrap-around is possible, because the count is clipped at acceptance.
- `start_i` in FILL or DONE is ignored, not queued. `ones_i` changes after acceptance have no effect.
- Count 0: one FILL cycle with no bit set, then DONE; `features_o` = 0.
- Reset (any state, including mid-FILL): next falling edge forces IDLE, `features_o`=0, `sat_o`=0, `done_o`=0, `busy_o`=0, `idx`=0, `remaining`=0. Reset has priority over `start_i` on the same edge.

## Timing

- Start accepted at falling edge k.
- `busy_o` high from k until edge k+max(T,1)+1, where T is the applied (clipped) count.
- Bit i is set at edge k+1+i.
- `done_o` high between edges k+max(T,1) and k+max(T,1)+1.
- Final vector is valid no later than the edge that raises `done_o`.
- Minimum spacing between accepted starts: max(T,1)+2 edges. A start held continuously high is re-accepted on the first edge back in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset mid-operation: INPUT_FEATURES=8, start with `ones_i`=5, assert `reset_i` after 3 FILL edges → next edge: `features_o`=0, `busy_o`=0, `done_o`=0, FSM IDLE. The following start with `ones_i`=2 yields 8'b0000_0011.
- Nominal: INPUT_FEATURES=8, `ones_i`=3, start at edge k → bits set at k+1..k+3; `done_o` pulses for one cycle after k+3; `features_o`=8'b0000_0111; `sat_o`=0.
- Boundaries:
  - `ones_i`=0 → `done_o` after edge k+1, `features_o`=0.
  - `ones_i`=8 → `features_o`=8'hFF, `done_o` after edge k+8, `sat_o`=0.
- Saturation: INPUT_FEATURES=8, `ones_i`=15 → `features_o`=8'hFF, `sat_o`=1, `done_o` after edge k+8. The next start with `ones_i`=1 clears `sat_o` and yields 8'h01.
- Ignored start: start with `ones_i`=4, then pulse `start_i` with `ones_i`=7 during FILL and during DONE → result stays 8'h0F, single `done_o` pulse. Holding `start_i`=1 continuously starts a new run on the first IDLE edge.
- Round trip: INPUT_FEATURES=13, every `ones_i` from 0 to 15 → `features_o` feeds `ones_counter`, whose `ones_o` equals min(`ones_i`, 13) one falling edge after `done_o`.
